// File: rtl/led_strip_pkg.sv
// Shared definitions for the two-wire LED strip protocol, used by both the
// matrix driver and the loopback/chain receiver.
package led_strip_pkg;

  localparam int FRAME_BITS  = 32;
  localparam int START_ZEROS = 32;
  localparam logic [2:0] HDR = 3'b111;

  localparam int HDR_MSB    = 31;
  localparam int HDR_LSB    = 29;
  localparam int BRIGHT_MSB = 28;
  localparam int BRIGHT_LSB = 24;
  localparam int B_MSB      = 23;
  localparam int B_LSB      = 16;
  localparam int G_MSB      = 15;
  localparam int G_LSB      = 8;
  localparam int R_MSB      = 7;
  localparam int R_LSB      = 0;

  typedef enum logic {HUNT = 1'b0, ALIGNED = 1'b1} rx_state_e;

  function automatic logic is_pixel(input logic [FRAME_BITS-1:0] word);
    return word[HDR_MSB:HDR_LSB] == HDR;
  endfunction

endpackage

// File: rtl/led_strip_rx_if.sv
// Strip pins in, decoded pixel stream and frame status out.
interface led_strip_rx_if #(
  parameter int IDX_W = 8
);
  logic             led_ck;
  logic             led_di;
  logic             pix_valid;
  logic [4:0]       pix_bright;
  logic [7:0]       pix_b;
  logic [7:0]       pix_g;
  logic [7:0]       pix_r;
  logic [IDX_W-1:0] pix_index;
  logic             frame_start;
  logic             frame_done;
  logic [IDX_W-1:0] frame_len;
  logic             frame_err;

  modport master (
    input  led_ck, led_di,
    output pix_valid, pix_bright, pix_b, pix_g, pix_r, pix_index,
           frame_start, frame_done, frame_len, frame_err
  );

  modport slave (
    output led_ck, led_di,
    input  pix_valid, pix_bright, pix_b, pix_g, pix_r, pix_index,
           frame_start, frame_done, frame_len, frame_err
  );
endinterface

// File: rtl/led_rx_sync.sv
// Brings the strip clock/data pins into the clk domain and emits one data
// sample per strip-clock rising edge.
module led_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic led_ck,
  input  logic led_di,
  output logic bit_stb,
  output logic bit_val
);

  logic [1:0] ck_sync_reg;
  logic [1:0] di_sync_reg;
  logic       ck_hist_reg;
  logic       stb_reg;
  logic       val_reg;

  // Data shares the clock's pipeline depth so the sample lines up with the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_sync_reg <= '0;
      di_sync_reg <= '0;
      ck_hist_reg <= 1'b0;
      stb_reg     <= 1'b0;
      val_reg     <= 1'b0;
    end else begin
      ck_sync_reg <= {ck_sync_reg[0], led_ck};
      di_sync_reg <= {di_sync_reg[0], led_di};
      ck_hist_reg <= ck_sync_reg[1];
      stb_reg     <= ck_sync_reg[1] & ~ck_hist_reg;
      val_reg     <= di_sync_reg[1];
    end
  end

  assign bit_stb = stb_reg;
  assign bit_val = val_reg;

endmodule

// File: rtl/led_strip_rx.sv
// LED strip receiver: hunts for the all-zero start frame, then decodes
// 32-bit LED frames into pixels with frame boundary/error reporting.
module led_strip_rx
  import led_strip_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int IDX_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  led_strip_rx_if.master bus
);

  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [5:0]       RUN_FULL = 6'(START_ZEROS);
  localparam int              BC_W     = $clog2(FRAME_BITS);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] CNT_MAX  = '1;

  logic bit_stb;
  logic bit_val;

  led_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .led_ck  (bus.led_ck),
    .led_di  (bus.led_di),
    .bit_stb (bit_stb),
    .bit_val (bit_val)
  );

  rx_state_e             state_reg;
  logic [5:0]            run_reg;
  logic [BC_W-1:0]       bit_cnt_reg;
  logic [FRAME_BITS-2:0] word_reg;
  logic [IDX_W-1:0]      count_reg;
  logic [TMO_W-1:0]      tmo_reg;

  logic                  pix_valid_reg;
  logic [4:0]            bright_reg;
  logic [7:0]            b_reg;
  logic [7:0]            g_reg;
  logic [7:0]            r_reg;
  logic [IDX_W-1:0]      index_reg;
  logic                  frame_start_reg;
  logic                  frame_done_reg;
  logic [IDX_W-1:0]      frame_len_reg;
  logic                  frame_err_reg;

  // Only the low 31 bits are stored; the incoming bit completes the word.
  logic [FRAME_BITS-1:0] word_shift;
  assign word_shift = {word_reg, bit_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= HUNT;
      run_reg         <= '0;
      bit_cnt_reg     <= '0;
      word_reg        <= '0;
      count_reg       <= '0;
      tmo_reg         <= '0;
      pix_valid_reg   <= 1'b0;
      bright_reg      <= '0;
      b_reg           <= '0;
      g_reg           <= '0;
      r_reg           <= '0;
      index_reg       <= '0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_len_reg   <= '0;
      frame_err_reg   <= 1'b0;
    end else begin
      pix_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;

      if (bit_stb)
        tmo_reg <= '0;
      else if (tmo_reg != TMO_MAX)
        tmo_reg <= tmo_reg + 1'b1;

      if (bit_stb) begin
        if (state_reg == HUNT) begin
          if (!bit_val) begin
            if (run_reg != RUN_FULL)
              run_reg <= run_reg + 1'b1;
          end else if (run_reg == RUN_FULL) begin
            // The aligning 1 is the header MSB of the first LED frame.
            state_reg       <= ALIGNED;
            frame_start_reg <= 1'b1;
            word_reg        <= (FRAME_BITS-1)'(1);
            bit_cnt_reg     <= BC_W'(1);
          end else begin
            run_reg <= '0;
          end
        end else begin
          word_reg <= word_shift[FRAME_BITS-2:0];
          if (bit_cnt_reg != LAST_BIT) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end else begin
            bit_cnt_reg <= '0;
            if (is_pixel(word_shift)) begin
              pix_valid_reg <= 1'b1;
              bright_reg    <= word_shift[BRIGHT_MSB:BRIGHT_LSB];
              b_reg         <= word_shift[B_MSB:B_LSB];
              g_reg         <= word_shift[G_MSB:G_LSB];
              r_reg         <= word_shift[R_MSB:R_LSB];
              index_reg     <= count_reg;
              if (count_reg != CNT_MAX)
                count_reg <= count_reg + 1'b1;
            end else if (word_shift == '0) begin
              // An all-zero word doubles as the next start frame.
              if (count_reg != '0) begin
                frame_done_reg <= 1'b1;
                frame_len_reg  <= count_reg;
              end
              count_reg <= '0;
              state_reg <= HUNT;
              run_reg   <= RUN_FULL;
            end else begin
              frame_err_reg <= 1'b1;
              count_reg     <= '0;
              state_reg     <= HUNT;
              run_reg       <= '0;
            end
          end
        end
      end else if (state_reg == ALIGNED && tmo_reg == TMO_LAST) begin
        if (count_reg != '0) begin
          frame_done_reg <= 1'b1;
          frame_len_reg  <= count_reg;
        end
        count_reg   <= '0;
        bit_cnt_reg <= '0;
        word_reg    <= '0;
        state_reg   <= HUNT;
        run_reg     <= '0;
      end
    end
  end

  assign bus.pix_valid   = pix_valid_reg;
  assign bus.pix_bright  = bright_reg;
  assign bus.pix_b       = b_reg;
  assign bus.pix_g       = g_reg;
  assign bus.pix_r       = r_reg;
  assign bus.pix_index   = index_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.frame_done  = frame_done_reg;
  assign bus.frame_len   = frame_len_reg;
  assign bus.frame_err   = frame_err_reg;

endmodule
